// File: rtl/div_operand_queue.sv
// Operand FIFO, settle timer and registered result slot in front of a combinational array divider.
// Optional statistics counters are enabled with `define DIVQ_STATS_EN.
module div_operand_queue #(
    parameter int N      = 4,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_d,
    input  logic [N-1:0] in_m,
    output logic [N-1:0] div_d,
    output logic [N-1:0] div_m,
    input  logic [N-1:0] div_q,
    input  logic [N-1:0] div_r,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_q,
    output logic [N-1:0] out_r,
`ifdef DIVQ_STATS_EN
    output logic [15:0]  stat_ops,
    output logic [15:0]  stat_dz,
`endif
    output logic         out_dz
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_SETTLING,
        ST_READY
    } state_t;

    logic [N-1:0]  mem_d [DEPTH];
    logic [N-1:0]  mem_m [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic [CW-1:0] cnt, cnt_next;
    state_t        state, state_next;

    logic head_valid, full, push, pop, slot_free, capture, res_dz;
    logic [N-1:0] res_q, res_r;

    assign head_valid = (count != '0);
    assign full       = (count == FULL_CNT);
    assign in_ready   = !full && !rst;
    assign push       = in_valid && in_ready;
    assign slot_free  = !out_valid || out_ready;
    assign capture    = (state == ST_READY) && slot_free;
    assign pop        = capture;

    assign div_d = head_valid ? mem_d[rd_ptr] : '0;
    assign div_m = head_valid ? mem_m[rd_ptr] : '0;

    // Divide-by-zero ignores the divider and returns all-ones / dividend.
    assign res_dz = (div_m == '0);
    assign res_q  = res_dz ? '1 : div_q;
    assign res_r  = res_dz ? div_d : div_r;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        count_next = count;
        cnt_next   = cnt;
        state_next = state;

        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        // A fresh head (after a pop, or a push into an empty queue) restarts the settle time.
        if (pop || !head_valid)
            cnt_next = '0;
        else if (cnt != CNT_MAX)
            cnt_next = cnt + 1'b1;

        if (count_next == '0)
            state_next = ST_EMPTY;
        else if (cnt_next == CNT_MAX)
            state_next = ST_READY;
        else
            state_next = ST_SETTLING;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
            state  <= ST_EMPTY;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            cnt   <= cnt_next;
            state <= state_next;
        end
    end

    // NOTE: FIFO storage is not reset; entries are only visible through count, which is.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wr_ptr] <= in_d;
            mem_m[wr_ptr] <= in_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_dz    <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_q     <= res_q;
            out_r     <= res_r;
            out_dz    <= res_dz;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DIVQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops <= '0;
            stat_dz  <= '0;
        end else if (capture) begin
            stat_ops <= stat_ops + 16'd1;
            if (res_dz) stat_dz <= stat_dz + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_div_operand_queue.sv
// Directed bench for div_operand_queue: a SETTLE=1 instance for the main checks and a SETTLE=3 instance for latency.
// Define DIVQ_STATS_EN to also check the statistics counters.
module tb_div_operand_queue;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_dz;
    logic [N-1:0] in_d = '0, in_m = '0, div_d, div_m, div_q, div_r, out_q, out_r;

    logic         in_valid3 = 1'b0, in_ready3, out_valid3, out_dz3;
    logic [N-1:0] in_d3 = '0, in_m3 = '0, div_d3, div_m3, div_q3, div_r3, out_q3, out_r3;

`ifdef DIVQ_STATS_EN
    logic [15:0] stat_ops, stat_dz, stat_ops3, stat_dz3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural array divider; returns junk for M=0 so the substitution is visible.
    assign div_q  = (div_m  != '0) ? div_d  / div_m  : 4'h3;
    assign div_r  = (div_m  != '0) ? div_d  % div_m  : 4'h6;
    assign div_q3 = (div_m3 != '0) ? div_d3 / div_m3 : 4'h3;
    assign div_r3 = (div_m3 != '0) ? div_d3 % div_m3 : 4'h6;

    div_operand_queue #(.N(N), .DEPTH(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_m(in_m),
        .div_d(div_d), .div_m(div_m), .div_q(div_q), .div_r(div_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
`ifdef DIVQ_STATS_EN
        .stat_ops(stat_ops), .stat_dz(stat_dz),
`endif
        .out_dz(out_dz)
    );

    div_operand_queue #(.N(N), .DEPTH(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_d(in_d3), .in_m(in_m3),
        .div_d(div_d3), .div_m(div_m3), .div_q(div_q3), .div_r(div_r3),
        .out_valid(out_valid3), .out_ready(1'b1), .out_q(out_q3), .out_r(out_r3),
`ifdef DIVQ_STATS_EN
        .stat_ops(stat_ops3), .stat_dz(stat_dz3),
`endif
        .out_dz(out_dz3)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] d, input logic [N-1:0] m);
        in_valid = v;
        in_d     = d;
        in_m     = m;
    endtask

    task automatic expect_res(input string tag, input logic [N-1:0] q, input logic [N-1:0] r, input logic dz);
        check({tag, ".valid"}, 16'(out_valid), 16'd1);
        check({tag, ".q"},     16'(out_q),     16'(q));
        check({tag, ".r"},     16'(out_r),     16'(r));
        check({tag, ".dz"},    16'(out_dz),    16'(dz));
    endtask

    logic [N-1:0] tv_d [7] = '{4'd13, 4'd11, 4'd15, 4'd10, 4'd14, 4'd8, 4'd9};
    logic [N-1:0] tv_m [7] = '{4'd3,  4'd4,  4'd2,  4'd5,  4'd0,  4'd1, 4'd1};

    initial begin
        int acc;
        logic took;

        // Reset state
        tick(); tick();
        check("rst.in_ready",  16'(in_ready),  16'd0);
        check("rst.out_valid", 16'(out_valid), 16'd0);
        check("rst.out_q",     16'(out_q),     16'd0);
        check("rst.div_d",     16'(div_d),     16'd0);
        check("rst.div_m",     16'(div_m),     16'd0);
        rst = 1'b0;
        tick();
        check("rel.in_ready",  16'(in_ready),  16'd1);

        // 1: single op 12/5, valid after the push edge plus one
        out_ready = 1'b1;
        drive(1'b1, 4'd12, 4'd5);
        tick();
        drive(1'b0, '0, '0);
        check("t1.early_valid", 16'(out_valid), 16'd0);
        check("t1.div_d",       16'(div_d),     16'd12);
        check("t1.div_m",       16'(div_m),     16'd5);
        tick();
        expect_res("t1", 4'd2, 4'd2, 1'b0);
        tick();
        check("t1.consumed", 16'(out_valid), 16'd0);
        check("t1.hold_q",   16'(out_q),     16'd2);

        // 2: back-to-back ops drain one per cycle in order
        drive(1'b1, 4'd7, 4'd2); tick();
        check("t2.early_valid", 16'(out_valid), 16'd0);
        drive(1'b1, 4'd6, 4'd2); tick();
        expect_res("t2.a", 4'd3, 4'd1, 1'b0);
        drive(1'b1, 4'd9, 4'd4); tick();
        expect_res("t2.b", 4'd3, 4'd0, 1'b0);
        drive(1'b0, '0, '0); tick();
        expect_res("t2.c", 4'd2, 4'd1, 1'b0);
        tick();
        check("t2.idle", 16'(out_valid), 16'd0);

        // 3: divide by zero then a normal op
        drive(1'b1, 4'd9, 4'd0); tick();
        drive(1'b1, 4'd12, 4'd5); tick();
        expect_res("t3.dz", 4'hF, 4'd9, 1'b1);
        drive(1'b0, '0, '0); tick();
        expect_res("t3.nz", 4'd2, 4'd2, 1'b0);
        tick();

        // 4: stalled consumer fills DEPTH + 1, then drains in order
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, tv_d[acc], tv_m[acc]);
            took = in_ready;
            tick();
            if (took) acc++;
        end
        drive(1'b0, '0, '0);
        check("t4.accepted", 16'(acc),      16'd5);
        check("t4.full",     16'(in_ready), 16'd0);
        expect_res("t4.r0", 4'd4, 4'd1, 1'b0);
        out_ready = 1'b1;
        tick();
        check("t4.ready_back", 16'(in_ready), 16'd1);
        expect_res("t4.r1", 4'd2, 4'd3, 1'b0);
        tick(); expect_res("t4.r2", 4'd7, 4'd1, 1'b0);
        tick(); expect_res("t4.r3", 4'd2, 4'd0, 1'b0);
        tick(); expect_res("t4.r4", 4'hF, 4'd14, 1'b1);
        tick();
        check("t4.empty", 16'(out_valid), 16'd0);

        // 6: reset with three queued ops and a held result
        out_ready = 1'b0;
        drive(1'b1, 4'd3, 4'd1); tick();
        drive(1'b1, 4'd4, 4'd2); tick();
        drive(1'b1, 4'd5, 4'd1); tick();
        drive(1'b1, 4'd6, 4'd3); tick();
        drive(1'b0, '0, '0);
        expect_res("t6.held", 4'd3, 4'd0, 1'b0);
        rst = 1'b1;
        tick();
        check("t6.rst_valid", 16'(out_valid), 16'd0);
        check("t6.rst_ready", 16'(in_ready),  16'd0);
        check("t6.rst_q",     16'(out_q),     16'd0);
        check("t6.rst_div_d", 16'(div_d),     16'd0);
`ifdef DIVQ_STATS_EN
        check("t6.stat_ops0", stat_ops, 16'd0);
        check("t6.stat_dz0",  stat_dz,  16'd0);
`endif
        rst = 1'b0;
        tick();
        check("t6.rel_ready", 16'(in_ready), 16'd1);
        out_ready = 1'b1;
        tick(); tick();
        check("t6.no_stale", 16'(out_valid), 16'd0);

        drive(1'b1, 4'd5, 4'd0); tick();
        drive(1'b1, 4'd8, 4'd3); tick();
        expect_res("t6.a", 4'hF, 4'd5, 1'b1);
        drive(1'b1, 4'd6, 4'd2); tick();
        expect_res("t6.b", 4'd2, 4'd2, 1'b0);
        drive(1'b0, '0, '0); tick();
        expect_res("t6.c", 4'd3, 4'd0, 1'b0);
`ifdef DIVQ_STATS_EN
        check("t6.stat_ops", stat_ops, 16'd3);
        check("t6.stat_dz",  stat_dz,  16'd1);
`endif
        tick();

        // 5: SETTLE=3, the push edge counts as the first of four edges
        in_valid3 = 1'b1; in_d3 = 4'd12; in_m3 = 4'd5;
        tick();
        in_valid3 = 1'b0; in_d3 = '0; in_m3 = '0;
        check("t5.e1_valid", 16'(out_valid3), 16'd0);
        check("t5.div_d",    16'(div_d3),     16'd12);
        tick();
        check("t5.e2_valid", 16'(out_valid3), 16'd0);
        tick();
        check("t5.e3_valid", 16'(out_valid3), 16'd0);
        tick();
        check("t5.e4_valid", 16'(out_valid3), 16'd1);
        check("t5.q",        16'(out_q3),     16'd2);
        check("t5.r",        16'(out_r3),     16'd2);
        check("t5.dz",       16'(out_dz3),    16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
